data_mem_banked: RTL and testbench
==================================

DATA_MEM_BANKED -- requirements
Module: data_mem_banked

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: word-address width; depth DEPTH = 2**ADDR_W 32-bit words.
REQ-002 SHALL have parameter DATA_BASE_WORD, default 512: first word index of the data section (scrub region start).
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pc  in  32  instruction byte address; pc[1:0] ignored.
REQ-006 SHALL have port instruction  out  32  fetched word, registered.
REQ-007 SHALL have port d_req  in  1  data request valid.
REQ-008 SHALL have port d_we  in  1  1 = store, 0 = load.
REQ-009 SHALL have port d_addr  in  32  data byte address.
REQ-010 SHALL have port d_funct3  in  3  RV32I load/store funct3.
REQ-011 SHALL have port d_wdata  in  32  store data, right-aligned (byte/half in low bits).
REQ-012 SHALL have port d_ready  out  1  request accepted when d_req && d_ready.
REQ-013 SHALL have port d_rvalid  out  1  one-cycle load-response strobe.
REQ-014 SHALL have port d_rdata  out  32  extended load data.
REQ-015 SHALL have port d_fault  out  1  one-cycle fault strobe.

Function
REQ-016 SHALL store words little-endian; byte lane = d_addr[1:0], word index = d_addr[ADDR_W+1:2].
REQ-017 SHALL implement FSM states RST, SCRUB, RUN; RST -> SCRUB (macro on) or RUN (macro off) on first edge after reset release; SCRUB -> RUN after last scrub write.
REQ-018 SHALL assert d_ready only in RUN; in RUN d_ready stays 1 every cycle (back-to-back accepts, zero bubbles).
REQ-019 SHALL on accepted store write only the addressed lanes at that edge: SB (000) 1 lane from d_wdata[7:0], SH (001) lanes {a+1,a} from d_wdata[15:0], SW (010) all 4.
REQ-020 SHALL on accepted load return d_rdata with d_rvalid=1 exactly one cycle after acceptance: LB 000 sign-ext, LH 001 sign-ext, LW 010, LBU 100 zero-ext, LHU 101 zero-ext.
REQ-021 SHALL flag fault when: SH/LH with d_addr[0]=1; SW/LW with d_addr[1:0]!=0; funct3 not listed for that direction; d_addr[31:ADDR_W+2] != 0.
REQ-022 SHALL on a faulting request perform no write, pulse d_fault one cycle after acceptance, and for loads also pulse d_rvalid with d_rdata=0.
REQ-023 SHALL return new data for a load accepted the cycle after a store to the same word (no stale read).
REQ-024 SHALL hold d_rdata at last value when d_rvalid=0; d_rvalid and d_fault SHALL never exceed one cycle per request.
REQ-025 SHALL register instruction one cycle after pc in all states; pc beyond DEPTH returns 32'h00000013 (NOP).

Reset
REQ-026 SHALL on rst=0 immediately force: state RST, d_ready=0, d_rvalid=0, d_fault=0, d_rdata=0, instruction=32'h00000013, scrub counter=DATA_BASE_WORD.
REQ-027 SHALL leave memory contents untouched by reset itself (instruction image preserved).
REQ-028 SHALL, on reset asserted mid-scrub or mid-response, drop any pending response and restart the scrub from DATA_BASE_WORD.

Configuration
REQ-029 SHALL compile the SCRUB state only when macro DATA_MEM_SCRUB_EN is defined: one word per cycle zeroed from DATA_BASE_WORD to DEPTH-1 (DEPTH-DATA_BASE_WORD cycles, d_ready=0 throughout), then RUN.
REQ-030 SHALL, without DATA_MEM_SCRUB_EN, enter RUN one cycle after reset release with memory unchanged.

Verification
REQ-031 SHALL cover: SW 0xDEADBEEF @0x800, then LB/LBU/LH/LHU/LW @0x800,0x801,0x802 -> 0xFFFFFFEF, 0x000000BE, 0xFFFFDEAD, 0x0000DEAD, 0xDEADBEEF respectively, each rvalid 1 cycle after accept.
REQ-032 SHALL cover: SB 0x55 @0x803 over 0xDEADBEEF, then LW @0x800 next cycle -> 0x55ADBEEF (read-after-write).
REQ-033 SHALL cover: LW @0x802, SH @0x801, funct3=011, addr 0x1000 (ADDR_W=10) -> d_fault pulse each, memory unchanged, faulting load d_rdata=0.
REQ-034 SHALL cover (macro on): preload word 600=0x12345678, word 10=0xABCD0000, reset -> d_ready low 512 cycles; then LW 0x960 -> 0, LW 0x28 -> 0xABCD0000.
REQ-035 SHALL cover: reset asserted at scrub cycle 100 -> outputs reset at once, scrub restarts, d_ready high exactly 512 cycles after release+1; pc=0x1000 -> instruction 0x00000013.

Source files
------------

// File: rtl/data_mem_banked.sv
// Unified instruction/data word memory with a registered fetch port and an RV32I load/store port.
// Define DATA_MEM_SCRUB_EN to zero words DATA_BASE_WORD..DEPTH-1 after every reset release.
module data_mem_banked #(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned DATA_BASE_WORD = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] instruction,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_fault
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        StRst,
`ifdef DATA_MEM_SCRUB_EN
        StScrub,
`endif
        StRun
    } state_e;

    logic [31:0] mem [DEPTH];

    state_e      state_q, state_d;
    logic        d_ready_q, d_ready_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic        d_fault_q, d_fault_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic [31:0] instr_q, instr_d;
`ifdef DATA_MEM_SCRUB_EN
    logic [ADDR_W-1:0] scrub_q, scrub_d;
`endif

    logic [ADDR_W-1:0] d_idx;
    logic [1:0]        lane;
    logic              addr_oob, bad_f3, misalign, fault, accept;
    logic [31:0]       rd_word, load_val;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_idx;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              unused_pc;

    assign unused_pc = ^pc[1:0];
    assign d_idx     = d_addr[ADDR_W+1:2];
    assign lane      = d_addr[1:0];
    assign addr_oob  = |(d_addr >> (ADDR_W + 2));
    assign accept    = d_req && d_ready_q;
    assign rd_word   = mem[d_idx];
    assign rd_byte   = 8'(rd_word >> {lane, 3'b000});
    assign rd_half   = lane[1] ? rd_word[31:16] : rd_word[15:0];

    // Legality depends on direction: only loads have the unsigned variants.
    always_comb begin
        bad_f3   = 1'b0;
        misalign = 1'b0;
        case (d_funct3)
            3'b000:  ;
            3'b001:  misalign = lane[0];
            3'b010:  misalign = |lane;
            3'b100:  bad_f3 = d_we;
            3'b101: begin
                bad_f3   = d_we;
                misalign = lane[0];
            end
            default: bad_f3 = 1'b1;
        endcase
    end

    assign fault = bad_f3 | misalign | addr_oob;

    always_comb begin
        case (d_funct3)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_val = {24'b0, rd_byte};
            3'b101:  load_val = {16'b0, rd_half};
            default: load_val = rd_word;
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = d_idx;
        mem_wdata = d_wdata;
        mem_be    = 4'b0000;
        if (accept && d_we && !fault) begin
            mem_we = 1'b1;
            case (d_funct3)
                3'b000: begin
                    mem_wdata = {4{d_wdata[7:0]}};
                    mem_be    = 4'b0001 << lane;
                end
                3'b001: begin
                    mem_wdata = {2{d_wdata[15:0]}};
                    mem_be    = lane[1] ? 4'b1100 : 4'b0011;
                end
                default: mem_be = 4'b1111;
            endcase
        end
`ifdef DATA_MEM_SCRUB_EN
        if (state_q == StScrub) begin
            mem_we    = 1'b1;
            mem_idx   = scrub_q;
            mem_wdata = 32'b0;
            mem_be    = 4'b1111;
        end
`endif
    end

    // No reset here: the instruction image must survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef DATA_MEM_SCRUB_EN
        scrub_d = scrub_q;
`endif
        case (state_q)
`ifdef DATA_MEM_SCRUB_EN
            StRst:   state_d = StScrub;
            StScrub: begin
                scrub_d = scrub_q + 1'b1;
                if (scrub_q == '1) state_d = StRun;
            end
`else
            StRst:   state_d = StRun;
`endif
            StRun:   ;
            default: state_d = StRst;
        endcase

        d_ready_d  = (state_d == StRun);
        d_rvalid_d = accept && !d_we;
        d_fault_d  = accept && fault;
        d_rdata_d  = d_rdata_q;
        if (accept && !d_we) d_rdata_d = fault ? 32'b0 : load_val;
        instr_d    = (|(pc >> (ADDR_W + 2))) ? NOP : mem[pc[ADDR_W+1:2]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StRst;
            d_ready_q  <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_fault_q  <= 1'b0;
            d_rdata_q  <= 32'b0;
            instr_q    <= NOP;
`ifdef DATA_MEM_SCRUB_EN
            scrub_q    <= ADDR_W'(DATA_BASE_WORD);
`endif
        end else begin
            state_q    <= state_d;
            d_ready_q  <= d_ready_d;
            d_rvalid_q <= d_rvalid_d;
            d_fault_q  <= d_fault_d;
            d_rdata_q  <= d_rdata_d;
            instr_q    <= instr_d;
`ifdef DATA_MEM_SCRUB_EN
            scrub_q    <= scrub_d;
`endif
        end
    end

    assign d_ready     = d_ready_q;
    assign d_rvalid    = d_rvalid_q;
    assign d_fault     = d_fault_q;
    assign d_rdata     = d_rdata_q;
    assign instruction = instr_q;
endmodule

// File: tb/tb_data_mem_banked.sv
// Self-checking bench for data_mem_banked: byte-array reference model, directed and random traffic.
module tb_data_mem_banked;
    localparam int ADDR_W = 10;
    localparam int BASE   = 512;
    localparam int DEPTH  = 2 ** ADDR_W;
`ifdef DATA_MEM_SCRUB_EN
    localparam int READY_LAT = 1 + DEPTH - BASE;
`else
    localparam int READY_LAT = 1;
`endif

    logic        clk, rst;
    logic [31:0] pc, instruction;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [2:0]  d_funct3;
    logic        d_ready, d_rvalid, d_fault;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] mdl [4*DEPTH];

    data_mem_banked #(.ADDR_W(ADDR_W), .DATA_BASE_WORD(BASE)) dut (
        .clk(clk), .rst(rst), .pc(pc), .instruction(instruction),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_funct3(d_funct3),
        .d_wdata(d_wdata), .d_ready(d_ready), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_fault(d_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: byte-addressed little-endian memory, accesses of 1<<f3[1:0] bytes.
    task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic flt, output logic [31:0] rd);
        int size;
        logic legal;
        logic [31:0] v;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size  = 1 << f3[1:0];
        flt   = !legal || (addr % 32'(size) != 0) || (addr >= 32'(4 * DEPTH));
        rd    = 32'b0;
        if (!flt) begin
            if (we) begin
                for (int i = 0; i < size; i++) mdl[addr + i] = wd[8*i +: 8];
            end else begin
                v = 32'b0;
                for (int i = 0; i < size; i++) v = v | (32'(mdl[addr + i]) << (8 * i));
                if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
                rd = v;
            end
        end
    endtask

    function automatic logic [31:0] model_word(input int idx);
        return {mdl[4*idx+3], mdl[4*idx+2], mdl[4*idx+1], mdl[4*idx]};
    endfunction

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic rdy, output logic rv,
                         output logic flt, output logic [31:0] rd);
        d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wd;
        rdy = d_ready;
        @(posedge clk); #1;
        rv = d_rvalid; flt = d_fault; rd = d_rdata;
        d_req = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!d_ready && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n !== READY_LAT) begin
            n_fail++;
            $display("FAIL %s: ready after %0d cycles, required %0d", name, n, READY_LAT);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if ({d_ready, d_rvalid, d_fault} !== 3'b000 || d_rdata !== 32'b0
            || instruction !== 32'h13) begin
            n_fail++;
            $display("FAIL %s: rdy=%b rv=%b flt=%b rdata=%h instr=%h, required 0 0 0 0 00000013",
                     name, d_ready, d_rvalid, d_fault, d_rdata, instruction);
        end
    endtask

    task automatic zero_scrub_model();
`ifdef DATA_MEM_SCRUB_EN
        for (int i = 4 * BASE; i < 4 * DEPTH; i++) mdl[i] = 8'h00;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; d_req = 0; d_we = 0; d_addr = 0; d_funct3 = 0; d_wdata = 0; pc = 0;
        #2 rst = 1'b0;
        #1 check_reset_outputs("reset_values");
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        wait_ready("reset_release_latency");
    endtask

    task automatic test_fill();
        logic rdy, rv, flt, ef; logic [31:0] rd, er, wd;
        for (int i = 0; i < DEPTH; i++) begin
            wd = $urandom;
            model_access(1'b1, 3'b010, 32'(4 * i), wd, ef, er);
            issue(1'b1, 3'b010, 32'(4 * i), wd, rdy, rv, flt, rd);
            n_checks++;
            if (rdy !== 1'b1 || rv !== 1'b0 || flt !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_sw[%0d]: rdy=%b rv=%b flt=%b, required 1 0 0", i, rdy, rv, flt);
            end
        end
    endtask

    task automatic test_load_store();
        logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] ads [5] = '{32'h800, 32'h801, 32'h802, 32'h802, 32'h800};
        logic [31:0] exs [5] = '{32'hFFFF_FFEF, 32'h0000_00BE, 32'hFFFF_DEAD,
                                 32'h0000_DEAD, 32'hDEAD_BEEF};
        logic rdy, rv, flt, ef; logic [31:0] rd, er, held;
        model_access(1'b1, 3'b010, 32'h800, 32'hDEAD_BEEF, ef, er);
        issue(1'b1, 3'b010, 32'h800, 32'hDEAD_BEEF, rdy, rv, flt, rd);
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, f3s[i], ads[i], 32'b0, rdy, rv, flt, rd);
            n_checks++;
            if (rv !== 1'b1 || flt !== 1'b0 || rd !== exs[i]) begin
                n_fail++;
                $display("FAIL load_ext[%0d]: rv=%b flt=%b rdata=%h, required 1 0 %h",
                         i, rv, flt, rd, exs[i]);
            end
        end
        held = d_rdata;
        @(posedge clk); #1;
        n_checks++;
        if (d_rvalid !== 1'b0 || d_rdata !== held) begin
            n_fail++;
            $display("FAIL rdata_hold: rv=%b rdata=%h, required 0 %h", d_rvalid, d_rdata, held);
        end
        model_access(1'b1, 3'b000, 32'h803, 32'hAAAA_AA55, ef, er);
        issue(1'b1, 3'b000, 32'h803, 32'hAAAA_AA55, rdy, rv, flt, rd);
        issue(1'b0, 3'b010, 32'h800, 32'b0, rdy, rv, flt, rd);
        n_checks++;
        if (rdy !== 1'b1 || rv !== 1'b1 || rd !== 32'h55AD_BEEF) begin
            n_fail++;
            $display("FAIL raw_sb_lw: rdy=%b rv=%b rdata=%h, required 1 1 55adbeef", rdy, rv, rd);
        end
    endtask

    task automatic test_faults();
        logic        wes [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3s [4] = '{3'b010, 3'b001, 3'b011, 3'b010};
        logic [31:0] ads [4] = '{32'h802, 32'h801, 32'h800, 32'h1000};
        logic rdy, rv, flt; logic [31:0] rd;
        for (int i = 0; i < 4; i++) begin
            issue(wes[i], f3s[i], ads[i], 32'hFFFF_FFFF, rdy, rv, flt, rd);
            n_checks++;
            if (flt !== 1'b1 || rv !== !wes[i] || (!wes[i] && rd !== 32'b0)) begin
                n_fail++;
                $display("FAIL fault[%0d]: flt=%b rv=%b rdata=%h, required 1 %b 00000000",
                         i, flt, rv, rd, !wes[i]);
            end
            @(posedge clk); #1;
            n_checks++;
            if (d_fault !== 1'b0 || d_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL fault_pulse[%0d]: flt=%b rv=%b, required 0 0", i, d_fault, d_rvalid);
            end
        end
        issue(1'b0, 3'b010, 32'h800, 32'b0, rdy, rv, flt, rd);
        n_checks++;
        if (rd !== 32'h55AD_BEEF) begin
            n_fail++;
            $display("FAIL fault_no_write: rdata=%h, required 55adbeef", rd);
        end
    endtask

    task automatic test_random();
        logic we, rdy, rv, flt, ef; logic [2:0] f3; logic [31:0] addr, wd, rd, er;
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH - 1));
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'((1 << f3[1:0]) - 1);
            wd = $urandom;
            model_access(we, f3, addr, wd, ef, er);
            issue(we, f3, addr, wd, rdy, rv, flt, rd);
            n_checks++;
            if (rdy !== 1'b1 || rv !== !we || flt !== ef || (!we && rd !== er)) begin
                n_fail++;
                $display("FAIL random[%0d] we=%b f3=%0d a=%h: rdy=%b rv=%b flt=%b rdata=%h, required 1 %b %b %h",
                         i, we, f3, addr, rdy, rv, flt, rd, !we, ef, er);
            end
        end
    endtask

    task automatic test_fetch();
        int idx; logic [31:0] exp_w;
        for (int i = 0; i < 20; i++) begin
            idx = $urandom_range(0, DEPTH - 1);
            pc = 32'(4 * idx) | 32'($urandom_range(0, 3));
            exp_w = model_word(idx);
            if (i == 18) begin pc = 32'h1000; exp_w = 32'h13; end
            if (i == 19) begin pc = $urandom | 32'h8000_0000; exp_w = 32'h13; end
            @(posedge clk); #1;
            n_checks++;
            if (instruction !== exp_w) begin
                n_fail++;
                $display("FAIL fetch[%0d] pc=%h: instr=%h, required %h", i, pc, instruction, exp_w);
            end
        end
        pc = 0;
    endtask

    task automatic check_preserved(input string name);
        logic rdy, rv, flt; logic [31:0] rd; int idx;
        for (int i = 0; i < 24; i++) begin
            idx = (i < 4) ? i * (DEPTH / 4) + 3 : $urandom_range(0, DEPTH - 1);
            issue(1'b0, 3'b010, 32'(4 * idx), 32'b0, rdy, rv, flt, rd);
            n_checks++;
            if (rv !== 1'b1 || rd !== model_word(idx)) begin
                n_fail++;
                $display("FAIL %s word %0d: rv=%b rdata=%h, required 1 %h",
                         name, idx, rv, rd, model_word(idx));
            end
        end
    endtask

    task automatic test_reset_mid_response();
        logic rdy, rv, flt; logic [31:0] rd;
        issue(1'b0, 3'b010, 32'h800, 32'b0, rdy, rv, flt, rd);
        #1 rst = 1'b0;
        #1 check_reset_outputs("reset_mid_response");
        @(negedge clk) rst = 1'b1;
        wait_ready("mid_response_release_latency");
        zero_scrub_model();
        check_preserved("after_reset");
    endtask

`ifdef DATA_MEM_SCRUB_EN
    task automatic test_scrub();
        logic rdy, rv, flt, ef; logic [31:0] rd, er;
        model_access(1'b1, 3'b010, 32'h960, 32'h1234_5678, ef, er);
        issue(1'b1, 3'b010, 32'h960, 32'h1234_5678, rdy, rv, flt, rd);
        model_access(1'b1, 3'b010, 32'h28, 32'hABCD_0000, ef, er);
        issue(1'b1, 3'b010, 32'h28, 32'hABCD_0000, rdy, rv, flt, rd);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        repeat (101) @(posedge clk);
        #1;
        n_checks++;
        if (d_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL scrub_ready_low: rdy=%b, required 0", d_ready);
        end
        rst = 1'b0;
        #1 check_reset_outputs("reset_mid_scrub");
        pc = 32'h1000;
        @(negedge clk) rst = 1'b1;
        wait_ready("scrub_restart_latency");
        n_checks++;
        if (instruction !== 32'h13) begin
            n_fail++;
            $display("FAIL pc_oob_nop: instr=%h, required 00000013", instruction);
        end
        pc = 0;
        zero_scrub_model();
        issue(1'b0, 3'b010, 32'h960, 32'b0, rdy, rv, flt, rd);
        n_checks++;
        if (rd !== 32'b0) begin
            n_fail++;
            $display("FAIL scrubbed_word600: rdata=%h, required 00000000", rd);
        end
        issue(1'b0, 3'b010, 32'h28, 32'b0, rdy, rv, flt, rd);
        n_checks++;
        if (rd !== 32'hABCD_0000) begin
            n_fail++;
            $display("FAIL kept_word10: rdata=%h, required abcd0000", rd);
        end
        check_preserved("after_scrub");
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_load_store();
        test_faults();
        test_random();
        test_fetch();
        test_reset_mid_response();
`ifdef DATA_MEM_SCRUB_EN
        test_scrub();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
